uart_transceiver: RTL and testbench

- Full-duplex 8N1 UART block with one transmitter and one receiver sharing a single clock and reset.
- The transmitter serialises a byte on a one-cycle trigger.
- The receiver deserialises an asynchronous serial line and pulses a valid strobe per good frame.
- Sits between the system bus logic and the board serial pins; loopback (tx_dout tied to rx_din) is the primary verification configuration.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_core.sv | 86 ++++++++
 rtl/uart_transceiver.sv | 145 ++++++++++++++
 tb/tb_uart_transceiver.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART slice (uart_tx_core, uart_transceiver).
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  typedef tx_state_t rx_state_t;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;

  function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Width of a counter running 0..n-1
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serialiser: captures din on trigger while idle and shifts it out LSB first.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 trigger,
  output logic                 dout,
  output logic                 busy
);

  localparam int unsigned          CNT_W    = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]           BIT_LAST = 3'(DATA_BITS - 1);

  tx_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [2:0]             bit_q, bit_d;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    dout    = STOP_BIT;
    busy    = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          shift_d = din;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        dout = START_BIT;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        dout = shift_q[0];
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) state_d = STOP;
          else                   bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: uart_tx_core transmitter plus inline receiver.
// Define UART_FRAME_ERR_EN to add the rx_ferr framing-error pulse output.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115_200
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic [7:0] tx_din,
  input  logic       tx_trigger,
  output logic       tx_dout,
  output logic       tx_busy,
  input  logic       rx_din,
  output logic [7:0] rx_dout,
  output logic       rx_dvalid
`ifdef UART_FRAME_ERR_EN
  ,
  output logic       rx_ferr
`endif
);

  localparam int unsigned      CLKS_PER_BIT = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned      CNT_W        = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST    = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       BIT_LAST     = 3'(DATA_BITS - 1);

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk     (clk),
    .rst_    (rst_),
    .din     (tx_din),
    .trigger (tx_trigger),
    .dout    (tx_dout),
    .busy    (tx_busy)
  );

  logic [1:0] sync_q;
  logic       rx_line;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) sync_q <= '1;
    else       sync_q <= {sync_q[0], rx_din};
  end

  assign rx_line = sync_q[1];

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           dout_d;
  logic                 dvalid_d;
`ifdef UART_FRAME_ERR_EN
  logic                 ferr_d;
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      bit_q     <= '0;
      rx_dout   <= '0;
      rx_dvalid <= 1'b0;
`ifdef UART_FRAME_ERR_EN
      rx_ferr   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      rx_dout   <= dout_d;
      rx_dvalid <= dvalid_d;
`ifdef UART_FRAME_ERR_EN
      rx_ferr   <= ferr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    dout_d   = rx_dout;
    dvalid_d = 1'b0;
`ifdef UART_FRAME_ERR_EN
    ferr_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (rx_line == START_BIT) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        // Half-bit recheck aligns later samples to bit centres and rejects glitches
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          if (rx_line == START_BIT) state_d = DATA;
          else                      state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_line, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) state_d = STOP;
          else                   bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        // Leave at the stop-bit centre so an early following start bit is caught
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_line == STOP_BIT) begin
            dout_d   = shift_q;
            dvalid_d = 1'b1;
          end
`ifdef UART_FRAME_ERR_EN
          else begin
            ferr_d = 1'b1;
          end
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Randomized loopback/bit-banged bench for uart_transceiver against a frame-level reference model.
module tb_uart_transceiver;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic [7:0] tx_din = '0;
  logic       tx_trigger = 1'b0;
  logic       tx_dout, tx_busy;
  logic       rx_din;
  logic [7:0] rx_dout;
  logic       rx_dvalid;
`ifdef UART_FRAME_ERR_EN
  logic       rx_ferr;
`endif

  logic loopback = 1'b1;
  logic rx_drv   = 1'b1;
  assign rx_din = loopback ? tx_dout : rx_drv;

  uart_transceiver #(
    .CLK_FREQ(1_600_000),
    .BAUD    (100_000)
  ) dut (
    .clk        (clk),
    .rst_       (rst_),
    .tx_din     (tx_din),
    .tx_trigger (tx_trigger),
    .tx_dout    (tx_dout),
    .tx_busy    (tx_busy),
    .rx_din     (rx_din),
    .rx_dout    (rx_dout),
    .rx_dvalid  (rx_dvalid)
`ifdef UART_FRAME_ERR_EN
    ,
    .rx_ferr    (rx_ferr)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int last_valid_cyc = 0;
  int accept_cyc = 0;
  int busy_run = 0;
  int last_busy = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Receive scoreboard: every valid strobe must deliver the oldest outstanding byte
  always @(negedge clk) begin
    if (rst_ && rx_dvalid) begin
      n_valid <= n_valid + 1;
      last_valid_cyc <= cyc;
      if (exp_q.size() != 0) chk("rx_byte", {24'h0, rx_dout}, {24'h0, exp_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!rst_) busy_run <= 0;
    else if (tx_busy) busy_run <= busy_run + 1;
    else if (busy_run != 0) begin
      last_busy <= busy_run;
      busy_run  <= 0;
    end
  end

`ifdef UART_FRAME_ERR_EN
  always @(negedge clk) begin
    if (rst_ && rx_ferr) begin
      n_ferr <= n_ferr + 1;
      chk("ferr_excl_dvalid", {31'h0, rx_dvalid}, 32'h0);
    end
  end
`endif

  function automatic logic frame_bit(input logic [7:0] d, input int k, input logic stop);
    if (k == 0) return 1'b0;
    if (k == 9) return stop;
    return d[k-1];
  endfunction

  task automatic wait_tx_idle();
    for (int i = 0; i < 20 * CPB; i++) begin
      if (!tx_busy) break;
      @(negedge clk);
    end
    chk("tx_idle_timeout", {31'h0, tx_busy}, 32'h0);
  endtask

  // Starts and returns on a negedge; wave=1 also checks each bit at its centre
  task automatic send_tx(input logic [7:0] d, input bit wave);
    wait_tx_idle();
    tx_din = d;
    tx_trigger = 1'b1;
    @(posedge clk);
    #1;
    tx_trigger = 1'b0;
    accept_cyc = cyc;
    tx_din = 8'($urandom);
    chk("busy_rise", {31'h0, tx_busy}, 32'h1);
    if (loopback) exp_q.push_back(d);
    if (wave) begin
      repeat (CPB / 2 + 1) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
        if (k != 0) repeat (CPB) @(negedge clk);
        chk($sformatf("tx_bit%0d", k), {31'h0, tx_dout}, {31'h0, frame_bit(d, k, 1'b1)});
      end
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic send_line(input logic [7:0] d, input logic stop);
    for (int k = 0; k < 10; k++) begin
      rx_drv = frame_bit(d, k, stop);
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 * CPB; i++) begin
      if (exp_q.size() == 0 && !tx_busy) break;
      @(negedge clk);
    end
    chk("rx_drain", exp_q.size(), 32'h0);
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int fbase;
    logic [7:0] hello [6] = '{8'h55, 8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    logic [7:0] d;

    repeat (3) @(negedge clk);
    chk("rst_tx_dout", {31'h0, tx_dout}, 32'h1);
    chk("rst_tx_busy", {31'h0, tx_busy}, 32'h0);
    chk("rst_rx_dout", {24'h0, rx_dout}, 32'h0);
    chk("rst_rx_dvalid", {31'h0, rx_dvalid}, 32'h0);
    rst_ = 1'b1;
    repeat (4) @(negedge clk);

    // Single 'A' in loopback with waveform, busy length and latency checks
    base = n_valid;
    send_tx(8'h41, 1'b1);
    drain();
    chk("A_busy_len", last_busy, 10 * CPB);
    chk("A_valid_count", n_valid - base, 1);
    chk("A_latency", last_valid_cyc - accept_cyc, 9 * CPB + CPB / 2 + 3);

    // Back-to-back frames, each triggered in the first idle cycle
    base = n_valid;
    foreach (hello[i]) send_tx(hello[i], 1'b1);
    drain();
    chk("hello_valid_count", n_valid - base, 6);

    // Trigger during a frame is ignored
    base = n_valid;
    send_tx(8'hFF, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    tx_din = 8'h11;
    tx_trigger = 1'b1;
    @(negedge clk);
    tx_trigger = 1'b0;
    chk("midframe_busy", {31'h0, tx_busy}, 32'h1);
    wait_tx_idle();
    repeat (2) @(negedge clk);
    chk("midframe_busy_len", last_busy, 10 * CPB);
    repeat (12 * CPB) @(negedge clk);
    drain();
    chk("midframe_no_retx", {31'h0, tx_busy}, 32'h0);
    chk("midframe_valid_count", n_valid - base, 1);

    // Short low glitch is rejected, then a clean frame is received
    loopback = 1'b0;
    base = n_valid;
    rx_drv = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("glitch_no_valid", n_valid - base, 0);
    exp_q.push_back(8'hA5);
    send_line(8'hA5, 1'b1);
    drain();
    chk("glitch_then_A5_count", n_valid - base, 1);

    // Framing error: byte discarded, output held
    base = n_valid;
    fbase = n_ferr;
    send_line(8'h3C, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    chk("ferr_no_valid", n_valid - base, 0);
    chk("ferr_rx_dout_held", {24'h0, rx_dout}, 32'hA5);
`ifdef UART_FRAME_ERR_EN
    chk("ferr_pulse_count", n_ferr - fbase, 1);
`endif

    // Reset mid-frame, then a clean frame
    loopback = 1'b1;
    send_tx(8'hF0, 1'b0);
    repeat (4 * CPB) @(negedge clk);
    rst_ = 1'b0;
    #1;
    chk("midrst_tx_dout", {31'h0, tx_dout}, 32'h1);
    chk("midrst_tx_busy", {31'h0, tx_busy}, 32'h0);
    chk("midrst_rx_dout", {24'h0, rx_dout}, 32'h0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_ = 1'b1;
    repeat (2) @(negedge clk);
    base = n_valid;
    send_tx(8'h0F, 1'b1);
    drain();
    chk("post_rst_valid_count", n_valid - base, 1);
    chk("post_rst_busy_len", last_busy, 10 * CPB);

    // Random loopback traffic with random idle gaps
    base = n_valid;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(0, 255));
      send_tx(d, (i % 2) == 0);
      repeat ($urandom_range(0, 3 * CPB)) @(negedge clk);
    end
    drain();
    chk("rand_valid_count", n_valid - base, 8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
